mc_ctrl_fsm: RTL and testbench

Multicycle control sequencer for the non-pipelined CPU datapath. It walks each instruction through FETCH/DECODE/EXEC/MEM/WB/MDWAIT and drives every datapath select code and write strobe: the 8:1 PC source, 4:1 ALU-B, 2:1 ALU-A, 8:1 write-back and destination-register selectors. It also handles the data-memory and multiply/divide handshakes and counts retired instructions.

---
 rtl/mc_ctrl_fsm.sv | 235 +++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// Multicycle control sequencer: walks each instruction through FETCH/DECODE/EXEC/MEM/WB/MDWAIT,
// drives datapath selects and strobes, handles memory and mul/div handshakes, counts retired instructions.
module mc_ctrl_fsm (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   input  logic        md_busy,
   output logic [2:0]  pc_sel,
   output logic        alu_a_sel,
   output logic [1:0]  alu_b_sel,
   output logic [2:0]  wb_sel,
   output logic [1:0]  rd_sel,
   output logic        pc_we,
   output logic        ir_we,
   output logic        ab_we,
   output logic        rf_we,
   output logic        mem_re,
   output logic        mem_we,
   output logic        md_start,
   output logic [2:0]  state,
   output logic [31:0] retired
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_MEM    = 3'd3;
   localparam logic [2:0] S_WB     = 3'd4;
   localparam logic [2:0] S_MDWAIT = 3'd5;

   localparam logic [3:0] C_NOP  = 4'd0;
   localparam logic [3:0] C_RALU = 4'd1;
   localparam logic [3:0] C_IALS = 4'd2;
   localparam logic [3:0] C_IALZ = 4'd3;
   localparam logic [3:0] C_LW   = 4'd4;
   localparam logic [3:0] C_SW   = 4'd5;
   localparam logic [3:0] C_BEQ  = 4'd6;
   localparam logic [3:0] C_BNE  = 4'd7;
   localparam logic [3:0] C_MD   = 4'd8;
   localparam logic [3:0] C_J    = 4'd9;
   localparam logic [3:0] C_JR   = 4'd10;
   localparam logic [3:0] C_JAL  = 4'd11;

   localparam logic [2:0] PC_SEQ  = 3'b000;
   localparam logic [2:0] PC_BR   = 3'b010;
   localparam logic [2:0] PC_JUMP = 3'b011;
   localparam logic [2:0] PC_REGA = 3'b100;

   localparam logic [1:0] B_REG  = 2'b00;
   localparam logic [1:0] B_SEXT = 2'b10;
   localparam logic [1:0] B_ZEXT = 2'b11;

   localparam logic [2:0] WB_ALU = 3'b000;
   localparam logic [2:0] WB_MEM = 3'b001;
   localparam logic [2:0] WB_PC4 = 3'b010;

   localparam logic [1:0] RD_RD = 2'b00;
   localparam logic [1:0] RD_RT = 2'b01;
   localparam logic [1:0] RD_RA = 2'b10;

   logic [2:0] state_q, state_d;
   logic [3:0] cls_q, dec_cls, cls;
   logic       br_taken;

   // Instruction class from the IR opcode/function fields
   always_comb begin
      dec_cls = C_NOP;
      case (op)
         6'h00: begin
            case (funct)
               6'h08:                      dec_cls = C_JR;
               6'h18, 6'h19, 6'h1A, 6'h1B: dec_cls = C_MD;
               default:                    dec_cls = C_RALU;
            endcase
         end
         6'h02:                      dec_cls = C_J;
         6'h03:                      dec_cls = C_JAL;
         6'h04:                      dec_cls = C_BEQ;
         6'h05:                      dec_cls = C_BNE;
         6'h08, 6'h09, 6'h0A, 6'h0B: dec_cls = C_IALS;
         6'h0C, 6'h0D, 6'h0E, 6'h0F: dec_cls = C_IALZ;
         6'h23:                      dec_cls = C_LW;
         6'h2B:                      dec_cls = C_SW;
         default:                    dec_cls = C_NOP;
      endcase
   end

   // DECODE acts on the live decode; later states use the latched class
   assign cls      = (state_q == S_DECODE) ? dec_cls : cls_q;
   assign br_taken = (cls == C_BEQ) ? zero : ~zero;
   assign state    = state_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         cls_q   <= C_NOP;
         retired <= 32'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) cls_q <= dec_cls;
         if ((state_q != S_FETCH) && (state_d == S_FETCH)) retired <= retired + 32'd1;
      end
   end

   always_comb begin
      state_d   = state_q;
      pc_sel    = PC_SEQ;
      alu_a_sel = 1'b0;
      alu_b_sel = B_REG;
      wb_sel    = WB_ALU;
      rd_sel    = RD_RD;
      pc_we     = 1'b0;
      ir_we     = 1'b0;
      ab_we     = 1'b0;
      rf_we     = 1'b0;
      mem_re    = 1'b0;
      mem_we    = 1'b0;
      md_start  = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_we   = 1'b1;
            pc_we   = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            ab_we = 1'b1;
            case (cls)
               C_J: begin
                  pc_sel  = PC_JUMP;
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end
               C_JR: begin
                  pc_sel  = PC_REGA;
                  pc_we   = 1'b1;
                  state_d = S_FETCH;
               end
               C_JAL:   state_d = S_WB;
               C_NOP:   state_d = S_FETCH;
               default: state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls)
               C_RALU: begin
                  alu_a_sel = 1'b1;
                  alu_b_sel = B_REG;
                  state_d   = S_WB;
               end
               C_IALS: begin
                  alu_a_sel = 1'b1;
                  alu_b_sel = B_SEXT;
                  state_d   = S_WB;
               end
               C_IALZ: begin
                  alu_a_sel = 1'b1;
                  alu_b_sel = B_ZEXT;
                  state_d   = S_WB;
               end
               C_LW, C_SW: begin
                  alu_a_sel = 1'b1;
                  alu_b_sel = B_SEXT;
                  state_d   = S_MEM;
               end
               C_BEQ, C_BNE: begin
                  alu_a_sel = 1'b1;
                  alu_b_sel = B_REG;
                  if (br_taken) begin
                     pc_sel = PC_BR;
                     pc_we  = 1'b1;
                  end
                  state_d = S_FETCH;
               end
               C_MD: begin
                  md_start = 1'b1;
                  state_d  = S_MDWAIT;
               end
               default: state_d = S_FETCH;
            endcase
         end
         S_MEM: begin
            if (cls == C_LW) mem_re = 1'b1;
            else             mem_we = 1'b1;
            if (mem_ready) state_d = (cls == C_LW) ? S_WB : S_FETCH;
         end
         S_WB: begin
            rf_we   = 1'b1;
            state_d = S_FETCH;
            case (cls)
               C_RALU: begin
                  rd_sel = RD_RD;
                  wb_sel = WB_ALU;
               end
               C_LW: begin
                  rd_sel = RD_RT;
                  wb_sel = WB_MEM;
               end
               C_JAL: begin
                  rd_sel = RD_RA;
                  wb_sel = WB_PC4;
                  pc_sel = PC_JUMP;
                  pc_we  = 1'b1;
               end
               default: begin
                  rd_sel = RD_RT;
                  wb_sel = WB_ALU;
               end
            endcase
         end
         S_MDWAIT: begin
            if (!md_busy) state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
      // Reset silences every select and strobe immediately
      if (rst) begin
         pc_sel    = PC_SEQ;
         alu_a_sel = 1'b0;
         alu_b_sel = B_REG;
         wb_sel    = WB_ALU;
         rd_sel    = RD_RD;
         pc_we     = 1'b0;
         ir_we     = 1'b0;
         ab_we     = 1'b0;
         rf_we     = 1'b0;
         mem_re    = 1'b0;
         mem_we    = 1'b0;
         md_start  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected cycle traces built from the instruction class
// rules, compared cycle by cycle against the sequencer outputs.
module tb_mc_ctrl_fsm;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  op, funct;
   logic        zero, mem_ready, md_busy;
   logic [2:0]  pc_sel;
   logic        alu_a_sel;
   logic [1:0]  alu_b_sel;
   logic [2:0]  wb_sel;
   logic [1:0]  rd_sel;
   logic        pc_we, ir_we, ab_we, rf_we, mem_re, mem_we, md_start;
   logic [2:0]  state;
   logic [31:0] retired;

   always #5 clk = ~clk;

   mc_ctrl_fsm dut (
      .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .md_busy(md_busy), .pc_sel(pc_sel),
      .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .wb_sel(wb_sel),
      .rd_sel(rd_sel), .pc_we(pc_we), .ir_we(ir_we), .ab_we(ab_we),
      .rf_we(rf_we), .mem_re(mem_re), .mem_we(mem_we), .md_start(md_start),
      .state(state), .retired(retired)
   );

   typedef enum int {K_NOP, K_R, K_IS, K_IZ, K_LW, K_SW, K_BEQ, K_BNE, K_MD, K_J, K_JR, K_JAL} kind_e;

   // One expected cycle: outputs followed by the inputs to apply in that cycle
   typedef struct packed {
      logic [2:0] st;
      logic [2:0] pc;
      logic       a;
      logic [1:0] b;
      logic [2:0] wb;
      logic [1:0] rd;
      logic [6:0] stb;
      logic       z;
      logic       mr;
      logic       mb;
   } cyc_t;

   localparam logic [6:0] PCW = 7'b1000000;
   localparam logic [6:0] IRW = 7'b0100000;
   localparam logic [6:0] ABW = 7'b0010000;
   localparam logic [6:0] RFW = 7'b0001000;
   localparam logic [6:0] MRE = 7'b0000100;
   localparam logic [6:0] MWE = 7'b0000010;
   localparam logic [6:0] MDS = 7'b0000001;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_ret;
   cyc_t        q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [20:0] obs();
      return {state, pc_sel, alu_a_sel, alu_b_sel, wb_sel, rd_sel,
              pc_we, ir_we, ab_we, rf_we, mem_re, mem_we, md_start};
   endfunction

   function automatic kind_e kind_of(input logic [5:0] o, input logic [5:0] f);
      if (o == 6'h00) begin
         if (f == 6'h08) return K_JR;
         if (f >= 6'h18 && f <= 6'h1B) return K_MD;
         return K_R;
      end
      if (o == 6'h02) return K_J;
      if (o == 6'h03) return K_JAL;
      if (o == 6'h04) return K_BEQ;
      if (o == 6'h05) return K_BNE;
      if (o >= 6'h08 && o <= 6'h0B) return K_IS;
      if (o >= 6'h0C && o <= 6'h0F) return K_IZ;
      if (o == 6'h23) return K_LW;
      if (o == 6'h2B) return K_SW;
      return K_NOP;
   endfunction

   function automatic cyc_t mk(input logic [2:0] st, input logic [6:0] stb);
      cyc_t c;
      c     = '0;
      c.st  = st;
      c.stb = stb;
      return c;
   endfunction

   // Expected cycle-by-cycle trace of one instruction
   task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z, input int m, input int w);
      cyc_t  c;
      kind_e k;
      logic  taken;
      k = kind_of(o, f);
      q.delete();
      q.push_back(mk(3'd0, PCW | IRW));
      c = mk(3'd1, ABW);
      if (k == K_J)  begin c.pc = 3'b011; c.stb |= PCW; end
      if (k == K_JR) begin c.pc = 3'b100; c.stb |= PCW; end
      q.push_back(c);
      case (k)
         K_NOP, K_J, K_JR: ;
         K_JAL: begin
            c = mk(3'd4, RFW | PCW);
            c.pc = 3'b011; c.rd = 2'b10; c.wb = 3'b010;
            q.push_back(c);
         end
         K_MD: begin
            q.push_back(mk(3'd2, MDS));
            for (int i = 0; i < w; i++) begin
               c = mk(3'd5, 7'd0);
               c.mb = (i < w - 1);
               q.push_back(c);
            end
         end
         K_BEQ, K_BNE: begin
            taken = (k == K_BEQ) ? z : !z;
            c = mk(3'd2, taken ? PCW : 7'd0);
            c.a = 1'b1; c.z = z;
            if (taken) c.pc = 3'b010;
            q.push_back(c);
         end
         default: begin
            c = mk(3'd2, 7'd0);
            c.a = 1'b1;
            c.b = (k == K_R) ? 2'b00 : (k == K_IZ) ? 2'b11 : 2'b10;
            q.push_back(c);
            if (k == K_LW || k == K_SW) begin
               for (int i = 0; i < m; i++) begin
                  c = mk(3'd3, (k == K_LW) ? MRE : MWE);
                  c.mr = (i == m - 1);
                  q.push_back(c);
               end
            end
            if (k != K_SW) begin
               c = mk(3'd4, RFW);
               c.rd = (k == K_R) ? 2'b00 : 2'b01;
               c.wb = (k == K_LW) ? 3'b001 : 3'b000;
               q.push_back(c);
            end
         end
      endcase
   endtask

   // Entered at a negedge in the FETCH cycle; returns at the negedge after the last cycle run
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input logic z,
                            input int m, input int w, input int limit);
      cyc_t e;
      build(o, f, z, m, w);
      for (int i = 0; i < q.size() && i < limit; i++) begin
         e         = q[i];
         op        = o;
         funct     = f;
         zero      = e.z;
         mem_ready = e.mr;
         md_busy   = e.mb;
         #1;
         check($sformatf("op%02h/%02h cyc%0d", o, f, i), 32'(obs()),
               32'({e.st, e.pc, e.a, e.b, e.wb, e.rd, e.stb}));
         if (e.st == 3'd0) check($sformatf("retired op%02h", o), retired, exp_ret);
         @(negedge clk);
      end
      if (limit >= q.size()) exp_ret = exp_ret + 32'd1;
   endtask

   task automatic rand_instr();
      logic [5:0] o, f;
      int         k;
      logic [5:0] unk [7];
      unk = '{6'h01, 6'h06, 6'h07, 6'h10, 6'h1F, 6'h20, 6'h3F};
      k = $urandom_range(0, 11);
      f = 6'($urandom);
      case (k)
         0:  o = unk[$urandom_range(0, 6)];
         1:  begin o = 6'h00; f = 6'(6'h20 + $urandom_range(0, 7)); end
         2:  o = 6'(6'h08 + $urandom_range(0, 3));
         3:  o = 6'(6'h0C + $urandom_range(0, 3));
         4:  o = 6'h23;
         5:  o = 6'h2B;
         6:  o = 6'h04;
         7:  o = 6'h05;
         8:  begin o = 6'h00; f = 6'(6'h18 + $urandom_range(0, 3)); end
         9:  o = 6'h02;
         10: begin o = 6'h00; f = 6'h08; end
         default: o = 6'h03;
      endcase
      run_instr(o, f, 1'($urandom), $urandom_range(1, 5), $urandom_range(1, 6), 1000);
   endtask

   initial begin
      rst = 1'b1; op = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0; md_busy = 1'b0;
      exp_ret = 32'd0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check($sformatf("reset outputs %0d", i), 32'(obs()), 32'd0);
         check($sformatf("reset retired %0d", i), retired, 32'd0);
      end
      rst = 1'b0;

      // Directed sequence
      run_instr(6'h00, 6'h20, 1'b0, 1, 1, 1000);   // add
      run_instr(6'h0D, 6'h00, 1'b0, 1, 1, 1000);   // ori
      run_instr(6'h23, 6'h00, 1'b0, 4, 1, 1000);   // lw, 4 MEM cycles
      run_instr(6'h2B, 6'h00, 1'b0, 1, 1, 1000);   // sw, ready at once
      run_instr(6'h04, 6'h00, 1'b1, 1, 1, 1000);   // beq taken
      run_instr(6'h05, 6'h00, 1'b1, 1, 1, 1000);   // bne not taken
      run_instr(6'h03, 6'h00, 1'b0, 1, 1, 1000);   // jal
      run_instr(6'h00, 6'h08, 1'b0, 1, 1, 1000);   // jr
      run_instr(6'h00, 6'h18, 1'b0, 1, 6, 1000);   // mult, busy 5 cycles
      run_instr(6'h3F, 6'h00, 1'b0, 1, 1, 1000);   // unknown opcode

      for (int n = 0; n < 60; n++) rand_instr();

      // Counter wrap: preload all-ones while in FETCH
      force dut.retired = 32'hFFFF_FFFF;
      #1;
      release dut.retired;
      exp_ret = 32'hFFFF_FFFF;
      run_instr(6'h02, 6'h00, 1'b0, 1, 1, 1000);
      run_instr(6'h00, 6'h21, 1'b0, 1, 1, 1000);

      // Reset in the middle of MDWAIT abandons the instruction
      run_instr(6'h00, 6'h1A, 1'b0, 1, 6, 5);
      rst = 1'b1;
      #1;
      check("rst mid-mdwait strobes", 32'(obs() & 21'h03FFFF), 32'd0);
      @(negedge clk);
      #1;
      check("rst mid-mdwait state", 32'(state), 32'd0);
      check("rst mid-mdwait retired", retired, 32'd0);
      rst = 1'b0;
      exp_ret = 32'd0;
      run_instr(6'h02, 6'h00, 1'b0, 1, 1, 1000);
      run_instr(6'h09, 6'h00, 1'b0, 1, 1, 1000);
      #1;
      check("final retired", retired, exp_ret);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
